// File: rtl/matvec_ctrl_if.sv
// matvec_ctrl_if: stream and datapath-control bundle between matvec_ctrl and its surroundings.
// Latency: none (wires only).
// Backpressure: carries the in_valid/in_ready and out_valid/out_ready pairs unchanged.
// Ports: master = controller side (drives in_ready, memory/acc controls, result status);
//        slave  = host/datapath side (drives start, in_valid, out_ready).
interface matvec_ctrl_if;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] addr_x;
   logic       wr_en_x;
   logic [3:0] addr_w;
   logic       wr_en_w;
   logic       clear_acc;
   logic       en_acc;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_row;
   logic       out_last;
   logic       busy;
   logic       done;

   modport master (
      input  start, in_valid, out_ready,
      output in_ready, addr_x, wr_en_x, addr_w, wr_en_w, clear_acc, en_acc,
             out_valid, out_row, out_last, busy, done
   );

   modport slave (
      output start, in_valid, out_ready,
      input  in_ready, addr_x, wr_en_x, addr_w, wr_en_w, clear_acc, en_acc,
             out_valid, out_row, out_last, busy, done
   );
endinterface

// File: rtl/matvec_ctrl.sv
// matvec_ctrl: sequencer for the 3x3 matrix-vector datapath (load W, load X, 3 MAC passes, emit y[0..2]).
// Latency: last X word in cycle t -> y[0] at t+5, y[1] at t+10, y[2] at t+15, done at t+16 (out_ready high).
// Backpressure: in_valid low stalls loading; out_ready low holds OUT with the accumulator frozen.
// Ports: clk, rst (sync, active high); bus = matvec_ctrl_if.master.
// Optional: MATVEC_CTRL_W_REUSE_EN adds input reuse_w; start & reuse_w skips LOAD_W and reuses stored W.
module matvec_ctrl (
   input  logic clk,
   input  logic rst,
`ifdef MATVEC_CTRL_W_REUSE_EN
   input  logic reuse_w,
`endif
   matvec_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_W, S_LOAD_X, S_CLEAR, S_MAC, S_OUT
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_w_q, cnt_w_d;
   logic [1:0] cnt_x_q, cnt_x_d;
   logic [1:0] k_q, k_d;
   logic [1:0] row_q, row_d;

   // Registered outputs, recomputed from the next state/counters so they line up with state_q.
   logic       in_ready_q, in_ready_d;
   logic [1:0] addr_x_q, addr_x_d;
   logic [3:0] addr_w_q, addr_w_d;
   logic       clear_acc_q, clear_acc_d;
   logic       en_acc_q, en_acc_d;
   logic       out_valid_q, out_valid_d;
   logic [1:0] out_row_q, out_row_d;
   logic       out_last_q, out_last_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic       in_hs;
   logic       skip_w;

`ifdef MATVEC_CTRL_W_REUSE_EN
   assign skip_w = reuse_w;
`else
   assign skip_w = 1'b0;
`endif

   // in_ready_q is only ever high in the load states, so this is the input handshake.
   assign in_hs = bus.in_valid & in_ready_q;

   always_comb begin
      state_d = state_q;
      cnt_w_d = cnt_w_q;
      cnt_x_d = cnt_x_q;
      k_d     = k_q;
      row_d   = row_q;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = skip_w ? S_LOAD_X : S_LOAD_W;
            end
         end
         S_LOAD_W: begin
            if (in_hs) begin
               if (cnt_w_q == 4'd8) begin
                  cnt_w_d = 4'd0;
                  state_d = S_LOAD_X;
               end else begin
                  cnt_w_d = cnt_w_q + 4'd1;
               end
            end
         end
         S_LOAD_X: begin
            if (in_hs) begin
               if (cnt_x_q == 2'd2) begin
                  cnt_x_d = 2'd0;
                  row_d   = 2'd0;
                  state_d = S_CLEAR;
               end else begin
                  cnt_x_d = cnt_x_q + 2'd1;
               end
            end
         end
         S_CLEAR: begin
            k_d     = 2'd0;
            state_d = S_MAC;
         end
         S_MAC: begin
            if (k_q == 2'd2) begin
               k_d     = 2'd0;
               state_d = S_OUT;
            end else begin
               k_d = k_q + 2'd1;
            end
         end
         S_OUT: begin
            if (bus.out_ready) begin
               if (row_q == 2'd2) begin
                  row_d   = 2'd0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  row_d   = row_q + 2'd1;
                  state_d = S_CLEAR;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      in_ready_d  = (state_d == S_LOAD_W) || (state_d == S_LOAD_X);
      clear_acc_d = (state_d == S_CLEAR);
      en_acc_d    = (state_d == S_MAC);
      out_valid_d = (state_d == S_OUT);
      out_row_d   = (state_d == S_OUT) ? row_d : 2'd0;
      out_last_d  = (state_d == S_OUT) && (row_d == 2'd2);
      busy_d      = (state_d != S_IDLE);

      addr_x_d = 2'd0;
      addr_w_d = 4'd0;
      case (state_d)
         S_LOAD_W: addr_w_d = cnt_w_d;
         S_LOAD_X: addr_x_d = cnt_x_d;
         S_MAC: begin
            addr_x_d = k_d;
            // 3*row + k, row-major W
            addr_w_d = {1'b0, row_d, 1'b0} + {2'b00, row_d} + {2'b00, k_d};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_w_q     <= 4'd0;
         cnt_x_q     <= 2'd0;
         k_q         <= 2'd0;
         row_q       <= 2'd0;
         in_ready_q  <= 1'b0;
         addr_x_q    <= 2'd0;
         addr_w_q    <= 4'd0;
         clear_acc_q <= 1'b0;
         en_acc_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_row_q   <= 2'd0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_w_q     <= cnt_w_d;
         cnt_x_q     <= cnt_x_d;
         k_q         <= k_d;
         row_q       <= row_d;
         in_ready_q  <= in_ready_d;
         addr_x_q    <= addr_x_d;
         addr_w_q    <= addr_w_d;
         clear_acc_q <= clear_acc_d;
         en_acc_q    <= en_acc_d;
         out_valid_q <= out_valid_d;
         out_row_q   <= out_row_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.addr_x    = addr_x_q;
   assign bus.addr_w    = addr_w_q;
   assign bus.wr_en_w   = in_hs & (state_q == S_LOAD_W);
   assign bus.wr_en_x   = in_hs & (state_q == S_LOAD_X);
   assign bus.clear_acc = clear_acc_q;
   assign bus.en_acc    = en_acc_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_row   = out_row_q;
   assign bus.out_last  = out_last_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_matvec_ctrl.sv
// tb_matvec_ctrl: drives matvec_ctrl with a behavioural datapath (memories + saturating accumulator)
// Latency: checks result cycles t+5/t+10/t+15 and done at t+16 relative to the last X word.
// Backpressure: exercises in_valid gaps and out_ready stalls.
module tb_matvec_ctrl;

   typedef logic [8:0][13:0] wvec_t;
   typedef logic [2:0][13:0] xvec_t;
   typedef logic [2:0][27:0] yvec_t;

   typedef struct packed {
      wvec_t      w;
      xvec_t      x;
      yvec_t      y;
      logic       gap;
      logic [3:0] stall;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   matvec_ctrl_if bus ();
   logic signed [13:0] in_data;
`ifdef MATVEC_CTRL_W_REUSE_EN
   logic reuse_w;
`endif

   matvec_ctrl dut (
      .clk     (clk),
      .rst     (rst),
`ifdef MATVEC_CTRL_W_REUSE_EN
      .reuse_w (reuse_w),
`endif
      .bus     (bus)
   );

   function automatic longint clip28(longint a);
      if (a > 64'sd134217727)  return 64'sd134217727;
      if (a < -64'sd134217728) return -64'sd134217728;
      return a;
   endfunction

   // Behavioural datapath obeying the controller's pins.
   logic signed [13:0] xmem [4];
   logic signed [13:0] wmem [16];
   logic signed [27:0] acc = '0;

   always @(posedge clk) begin
      if (bus.wr_en_x) xmem[bus.addr_x] <= in_data;
      if (bus.wr_en_w) wmem[bus.addr_w] <= in_data;
      if (bus.clear_acc)
         acc <= '0;
      else if (bus.en_acc)
         acc <= 28'(clip28(longint'(acc) + longint'(wmem[bus.addr_w]) * longint'(xmem[bus.addr_x])));
   end

   // Reference: y[r] = sum_k W[r][k]*x[k], saturating after every term.
   function automatic longint ref_y(wvec_t w, xvec_t x, int r);
      longint a = 0;
      for (int k = 0; k < 3; k++) begin
         a = clip28(a + longint'($signed(w[3*r+k])) * longint'($signed(x[k])));
      end
      return a;
   endfunction

   function automatic void chk(string name, longint got, longint exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   // Cycle-wide invariants.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (bus.clear_acc || bus.en_acc) chk("acc_excl", longint'(bus.clear_acc & bus.en_acc), 0);
         if (bus.wr_en_w || bus.wr_en_x) chk("wr_needs_rdy", longint'(bus.in_ready), 1);
      end
   end

   task automatic load_job(input wvec_t w, input xvec_t x, input bit gap, input bit hold_start,
                           input bit reuse, output int t_last);
      int  idx;
      int  n;
      bit  vld;
      t_last = 0;
      @(negedge clk);
      chk("idle_busy", longint'(bus.busy), 0);
      bus.start = 1'b1;
`ifdef MATVEC_CTRL_W_REUSE_EN
      reuse_w = reuse;
`endif
      @(negedge clk);
      bus.start = hold_start;
`ifdef MATVEC_CTRL_W_REUSE_EN
      reuse_w = 1'b0;
`endif
      chk("start_to_rdy", longint'(bus.in_ready), 1);
      idx = reuse ? 9 : 0;
      n   = 0;
      while (idx < 12) begin
         vld = gap ? (n % 2 == 0) : 1'b1;
         if (vld) begin
            if (idx < 9) chk("addr_w_load", longint'(bus.addr_w), idx);
            else         chk("addr_x_load", longint'(bus.addr_x), idx - 9);
            chk("in_ready_load", longint'(bus.in_ready), 1);
            in_data = (idx < 9) ? $signed(w[idx]) : $signed(x[idx-9]);
            t_last  = cyc;
         end else begin
            in_data = 14'sh1555;
         end
         bus.in_valid = vld;
         @(negedge clk);
         if (vld) idx++;
         n++;
         if (n > 40) begin
            chk("load_budget", idx, 12);
            break;
         end
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
   endtask

   task automatic run_job(input vec_t v, input bit hold_start, input bit reuse);
      int t;
      int wait_n;
      int st;
      st = int'(v.stall);
      bus.out_ready = (st == 0);
      load_job(v.w, v.x, v.gap, hold_start, reuse, t);
      chk("clear_after_load", longint'(bus.clear_acc), 1);
      chk("t_clear", cyc, t + 1);
      for (int r = 0; r < 3; r++) begin
         wait_n = 0;
         while (!bus.out_valid && wait_n < 30) begin
            @(negedge clk);
            wait_n++;
         end
         chk("t_out", cyc, t + 5 + r * (5 + st));
         chk("out_row", longint'(bus.out_row), r);
         chk("out_last", longint'(bus.out_last), (r == 2) ? 1 : 0);
         chk("y", longint'(acc), longint'($signed(v.y[r])));
         for (int s = 0; s < st; s++) begin
            @(negedge clk);
            chk("stall_valid", longint'(bus.out_valid), 1);
            chk("stall_quiet", longint'(bus.en_acc | bus.clear_acc), 0);
            chk("stall_y", longint'(acc), longint'($signed(v.y[r])));
         end
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = (st == 0);
         if (r < 2) chk("row_clear", longint'(bus.clear_acc), 1);
      end
      chk("done", longint'(bus.done), 1);
      chk("idle_after", longint'(bus.busy), 0);
      chk("t_done", cyc, t + 16 + 3 * st);
      @(negedge clk);
      chk("done_pulse", longint'(bus.done), 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"},      longint'(bus.busy), 0);
      chk({tag, "_in_ready"},  longint'(bus.in_ready), 0);
      chk({tag, "_clear_acc"}, longint'(bus.clear_acc), 0);
      chk({tag, "_en_acc"},    longint'(bus.en_acc), 0);
      chk({tag, "_out_valid"}, longint'(bus.out_valid), 0);
      chk({tag, "_out_last"},  longint'(bus.out_last), 0);
      chk({tag, "_done"},      longint'(bus.done), 0);
      chk({tag, "_addr_x"},    longint'(bus.addr_x), 0);
      chk({tag, "_addr_w"},    longint'(bus.addr_w), 0);
      chk({tag, "_out_row"},   longint'(bus.out_row), 0);
      chk({tag, "_wr_en"},     longint'(bus.wr_en_w | bus.wr_en_x), 0);
   endtask

   task automatic reset_mid_mac(input vec_t v);
      int t;
      bus.out_ready = 1'b1;
      load_job(v.w, v.x, 1'b0, 1'b0, 1'b0, t);
      while (cyc < t + 8) @(negedge clk);   // middle MAC cycle of row 1
      chk("pre_rst_mac", longint'(bus.en_acc), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("midrst");
   endtask

   vec_t tbl [6];
   vec_t rv;

   initial begin
      // 0 basic, 1 backpressure, 2 input gaps, 3 +sat, 4 -sat, 5 identity after mid-job reset
      for (int i = 0; i < 6; i++) tbl[i] = '0;
      for (int i = 0; i < 9; i++) begin
         tbl[0].w[i] = 14'(i + 1);
         tbl[3].w[i] = 14'sd8191;
         tbl[4].w[i] = -14'sd8192;
      end
      for (int k = 0; k < 3; k++) begin
         tbl[0].x[k] = 14'(k + 1);
         tbl[3].x[k] = 14'sd8191;
         tbl[4].x[k] = 14'sd8191;
      end
      tbl[0].y[0] = 28'sd14;  tbl[0].y[1] = 28'sd32;  tbl[0].y[2] = 28'sd50;
      tbl[1] = tbl[0]; tbl[1].stall = 4'd4;
      tbl[2] = tbl[0]; tbl[2].gap   = 1'b1;
      for (int r = 0; r < 3; r++) begin
         tbl[3].y[r] = 28'sd134217727;
         tbl[4].y[r] = -28'sd134217728;
      end
      tbl[5].w[0] = 14'sd1; tbl[5].w[4] = 14'sd1; tbl[5].w[8] = 14'sd1;
      tbl[5].x[0] = 14'sd5; tbl[5].x[1] = -14'sd6; tbl[5].x[2] = 14'sd7;
      tbl[5].y[0] = 28'sd5; tbl[5].y[1] = -28'sd6; tbl[5].y[2] = 28'sd7;

      rst = 1'b1;
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      in_data = '0;
`ifdef MATVEC_CTRL_W_REUSE_EN
      reuse_w = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // in_valid in IDLE must be ignored
      bus.in_valid = 1'b1;
      in_data = 14'sd99;
      @(negedge clk);
      chk("idle_in_ready", longint'(bus.in_ready), 0);
      chk("idle_wr_en", longint'(bus.wr_en_w | bus.wr_en_x), 0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("idle_stays", longint'(bus.busy), 0);

      for (int i = 0; i < 6; i++) begin
         if (i == 5) reset_mid_mac(tbl[0]);
         run_job(tbl[i], 1'b0, 1'b0);
      end

      // Random jobs; start held high while busy must be ignored.
      for (int j = 0; j < 16; j++) begin
         rv = '0;
         for (int i = 0; i < 9; i++)
            rv.w[i] = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 14'h1FFF : 14'h2000)
                                                   : 14'($urandom);
         for (int k = 0; k < 3; k++)
            rv.x[k] = ($urandom_range(0, 3) == 0) ? 14'h1FFF : 14'($urandom);
         for (int r = 0; r < 3; r++) rv.y[r] = 28'(ref_y(rv.w, rv.x, r));
         rv.gap   = 1'($urandom_range(0, 1));
         rv.stall = 4'($urandom_range(0, 2));
         run_job(rv, 1'($urandom_range(0, 1)), 1'b0);
      end

`ifdef MATVEC_CTRL_W_REUSE_EN
      run_job(tbl[0], 1'b0, 1'b0);
      rv = '0;
      rv.x[0] = 14'sd1;
      rv.y[0] = 28'sd1; rv.y[1] = 28'sd4; rv.y[2] = 28'sd7;
      run_job(rv, 1'b0, 1'b1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/matvec_ctrl.md
# matvec_ctrl

Sequencing controller for the 3x3 matrix-vector datapath (3-entry X memory, 9-entry W memory, 14x14 signed multiplier, 28-bit saturating accumulator). Accepts a start request, streams 9 W words and then 3 X words into the datapath memories over a valid/ready input channel, and runs three 3-term MAC passes. Each result y[i] = sum_k W[i][k]*x[k] is presented over a valid/ready output channel. The controller sits between the top-level stream interfaces and the datapath control pins; it carries no data itself.

## Interface
- No parameters; dimensions fixed at N=3 (9 W words, 3 X words).
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a job; sampled only in IDLE
- in_valid  in  1  input word (on datapath input_data) valid
- in_ready  out  1  controller accepts input word; high only in LOAD_W/LOAD_X
- addr_x  out  2  X memory address
- wr_en_x  out  1  X memory write = in_valid & in_ready in LOAD_X
- addr_w  out  4  W memory address
- wr_en_w  out  1  W memory write = in_valid & in_ready in LOAD_W
- clear_acc  out  1  clear accumulator
- en_acc  out  1  accumulate product into accumulator
- out_valid  out  1  datapath output_data holds y[out_row]
- out_ready  in  1  downstream accepts result
- out_row  out  2  row index of presented result
- out_last  out  1  high with out_valid when out_row==2
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after final result handshake

## Operation
- States: IDLE, LOAD_W, LOAD_X, CLEAR, MAC, OUT.
- IDLE: start=1 -> LOAD_W; otherwise stay. in_valid ignored.
- LOAD_W: in_ready=1, addr_w=cnt_w (0..8, row-major W[i][k] at 3i+k); each handshake writes and increments cnt_w; handshake at cnt_w==8 -> LOAD_X.
- LOAD_X: in_ready=1, addr_x=cnt_x (0..2); handshake at cnt_x==2 -> CLEAR with row=0.
- CLEAR: clear_acc=1 for exactly one cycle -> MAC with k=0.
- MAC: en_acc=1, addr_x=k, addr_w=3*row+k; k increments each cycle; at k==2 -> OUT.
- OUT: out_valid=1, out_row=row; hold until out_ready. On handshake: row<2 -> row+1, CLEAR; row==2 -> IDLE, done=1 next cycle.
- In CLEAR/OUT/IDLE: addr_x=0, addr_w=0 unless stated; wr_en_*=0, en_acc=0 outside MAC.
- clear_acc and en_acc never asserted together.
- Arithmetic entirely in datapath: signed 14x14 -> 28-bit product, saturating add; controller performs no width handling.
- Counter wrap: cnt_w, cnt_x, k, row reset to 0 on state exit; no counter exceeds its terminal value.
- in_valid low in a load state: stall, no write, no counter change.
- out_ready low in OUT: y held stable (en_acc=0, clear_acc=0).
- start while busy: ignored.

## Timing
- Reset: state IDLE, all counters 0; in_ready, wr_en_x, wr_en_w, clear_acc, en_acc, out_valid, out_last, busy, done = 0; addr_x=0, addr_w=0, out_row=0.
- Reset mid-operation: return to IDLE next edge; memory contents and accumulator untouched (no clear issued); job discarded.
- All outputs except wr_en_x/wr_en_w are decoded from registered state/counters only; wr_en_* combinational from in_valid.
- Load: 12 words minimum 12 cycles, one word per cycle at full rate.
- Compute latency: last X handshake in cycle t -> CLEAR at t+1, MAC at t+2..t+4, out_valid for row 0 at t+5.
- Per row with out_ready held high: 5 cycles (CLEAR, 3xMAC, OUT); results at t+5, t+10, t+15; done at t+16, also IDLE at t+16, start accepted at t+16.
- start to first in_ready: 1 cycle.

## Configuration
- MATVEC_CTRL_W_REUSE_EN defined: extra input port reuse_w (1 bit), sampled with start in IDLE; start & reuse_w -> LOAD_X directly, skipping LOAD_W and reusing stored W. start & !reuse_w behaves as baseline.
- Not defined: no reuse_w port; every job loads W then X.

## Test plan
- Basic: W=1..9 row-major, x=(1,2,3), out_ready=1 -> outputs 14, 32, 50 at t+5, t+10, t+15; out_last with 50; done at t+16.
- Backpressure: same data, out_ready low 4 cycles on each row -> each y held stable, no en_acc/clear_acc during stall, same values 14/32/50.
- Input gaps: in_valid toggled 1/0 during load -> only handshaked words written, addresses 0..8 then 0..2 in order, results unchanged.
- Signs/saturation: W all 8191, x all 8191 -> each y = 134217727 (saturated); W all -8192, x all 8191 -> each y = -201302016 clipped to -134217728.
- Reset mid-MAC of row 1 -> next cycle IDLE, all outputs 0; new job with W=identity, x=(5,-6,7) -> 5, -6, 7.
- With MATVEC_CTRL_W_REUSE_EN: after basic job, start+reuse_w with x=(1,0,0) -> only 3 in_ready handshakes, outputs 1, 4, 7.
